// File: rtl/freddie_pkg.sv
// Shared types and constants for the Freddie DRAM-side responder.
package freddie_pkg;
   localparam int DEFAULT_ADDR_W = 8;
   localparam int REFRESH_CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      ROW_OPEN,
      COL_RD,
      COL_WR,
      CBR_ARM,
      REFRESH
   } dram_state_t;
endpackage

// File: rtl/freddie_dram_responder_if.sv
// Multiplexed DRAM bus between the Freddie controller (master) and the responder (slave).
interface freddie_dram_responder_if #(parameter int ADDR_W = freddie_pkg::DEFAULT_ADDR_W);
   logic              ras;
   logic              cas;
   logic              w;
   logic [ADDR_W-1:0] ba;
   logic [7:0]        din;
   logic [7:0]        dout;
   logic              dout_en;

   modport master (output ras, cas, w, ba, din, input dout, dout_en);
   modport slave  (input ras, cas, w, ba, din, output dout, dout_en);
endinterface

// File: rtl/freddie_dram_array.sv
// Byte-wide storage for the responder: synchronous write, registered read, contents never reset.
module freddie_dram_array #(
   parameter int ADDR_W = 8
) (
   input  logic                  clk_in,
   input  logic                  we,
   input  logic [2*ADDR_W-1:0]   waddr,
   input  logic [7:0]            wdata,
   input  logic                  re,
   input  logic [2*ADDR_W-1:0]   raddr,
   output logic [7:0]            rdata
);
   logic [7:0] mem [2**(2*ADDR_W)];

   always_ff @(posedge clk_in) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/freddie_dram_responder.sv
// Behavioural DRAM bank answering Freddie's ras/cas/w/ba bus, with refresh accounting and watchdog.
//   state    | meaning
//   IDLE     | no strobes active
//   ROW_OPEN | row latched, waiting for CAS or RAS release
//   COL_RD   | read in progress, data driven
//   COL_WR   | write committed, waiting for CAS release
//   CBR_ARM  | CAS fell first, waiting for RAS (CAS-before-RAS)
//   REFRESH  | refresh in progress, waiting for both strobes high
module freddie_dram_responder
   import freddie_pkg::*;
#(
   parameter int REFRESH_WINDOW = 4096,
   parameter int ADDR_W         = DEFAULT_ADDR_W
) (
   input  logic                      clk_in,
   input  logic                      rst,
   freddie_dram_responder_if.slave   bus,
   output logic [2*ADDR_W-1:0]       access_addr,
   output logic                      rd_strobe,
   output logic                      wr_strobe,
   output logic [REFRESH_CNT_W-1:0]  refresh_cnt,
   output logic                      refresh_late,
   output logic                      prot_err
);
   localparam int WD_W = $clog2(REFRESH_WINDOW + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(REFRESH_WINDOW);

   dram_state_t         state, state_n;
   logic                ras_q, cas_q, w_q;
   logic                ras_fall, ras_rise, cas_fall, cas_rise, w_fall;
   logic [ADDR_W-1:0]   row_q;
   logic                cas_seen;
   logic [WD_W-1:0]     wd_cnt;
   logic                mem_we, mem_re;
   logic [2*ADDR_W-1:0] mem_waddr;
   logic [7:0]          mem_rdata;
   logic                row_ld, col_ld, rd_pulse, wr_pulse, err_pulse, ref_ev;

   assign ras_fall = ras_q & ~bus.ras;
   assign ras_rise = ~ras_q & bus.ras;
   assign cas_fall = cas_q & ~bus.cas;
   assign cas_rise = ~cas_q & bus.cas;
   assign w_fall   = w_q & ~bus.w;

   assign bus.dout_en = (state == COL_RD);
   assign bus.dout    = bus.dout_en ? mem_rdata : 8'h00;

   freddie_dram_array #(.ADDR_W(ADDR_W)) u_array (
      .clk_in (clk_in),
      .we     (mem_we),
      .waddr  (mem_waddr),
      .wdata  (bus.din),
      .re     (mem_re),
      .raddr  ({row_q, bus.ba}),
      .rdata  (mem_rdata)
   );

   always_comb begin
      state_n   = state;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_waddr = access_addr;
      row_ld    = 1'b0;
      col_ld    = 1'b0;
      rd_pulse  = 1'b0;
      wr_pulse  = 1'b0;
      err_pulse = 1'b0;
      ref_ev    = 1'b0;
      case (state)
         IDLE: begin
            if (ras_fall && cas_fall) begin
               err_pulse = 1'b1;
               ref_ev    = 1'b1;
               state_n   = REFRESH;
            end else if (ras_fall && bus.cas) begin
               row_ld  = 1'b1;
               state_n = ROW_OPEN;
            end else if (cas_fall && bus.ras) begin
               state_n = CBR_ARM;
            end
         end
         ROW_OPEN: begin
            if (cas_fall) begin
               col_ld = 1'b1;
               if (!bus.w) begin
                  mem_we    = 1'b1;
                  mem_waddr = {row_q, bus.ba};
                  wr_pulse  = 1'b1;
                  state_n   = COL_WR;
               end else begin
                  mem_re   = 1'b1;
                  rd_pulse = 1'b1;
                  state_n  = COL_RD;
               end
            end else if (ras_rise) begin
               ref_ev  = ~cas_seen;
               state_n = IDLE;
            end
         end
         COL_RD: begin
            if (w_fall) begin
               mem_we   = 1'b1;
               wr_pulse = 1'b1;
               state_n  = COL_WR;
            end else if (cas_rise) begin
               // both strobes released together is a clean end of cycle
               state_n = bus.ras ? IDLE : ROW_OPEN;
            end else if (ras_rise) begin
               err_pulse = 1'b1;
               state_n   = IDLE;
            end
         end
         COL_WR: begin
            if (cas_rise) begin
               state_n = bus.ras ? IDLE : ROW_OPEN;
            end else if (ras_rise) begin
               err_pulse = 1'b1;
               state_n   = IDLE;
            end
         end
         CBR_ARM: begin
            if (ras_fall) begin
               ref_ev  = 1'b1;
               state_n = REFRESH;
            end else if (cas_rise) begin
               state_n = IDLE;
            end
         end
         REFRESH: begin
            if (bus.ras && bus.cas) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ras_q        <= 1'b1;
         cas_q        <= 1'b1;
         w_q          <= 1'b1;
         row_q        <= '0;
         cas_seen     <= 1'b0;
         access_addr  <= '0;
         rd_strobe    <= 1'b0;
         wr_strobe    <= 1'b0;
         prot_err     <= 1'b0;
         refresh_cnt  <= '0;
         wd_cnt       <= '0;
         refresh_late <= 1'b0;
      end else begin
         state     <= state_n;
         ras_q     <= bus.ras;
         cas_q     <= bus.cas;
         w_q       <= bus.w;
         rd_strobe <= rd_pulse;
         wr_strobe <= wr_pulse;
         prot_err  <= err_pulse;
         if (row_ld) begin
            row_q    <= bus.ba;
            cas_seen <= 1'b0;
         end else if (col_ld) begin
            cas_seen <= 1'b1;
         end
         if (col_ld) access_addr <= {row_q, bus.ba};
         if (ref_ev) refresh_cnt <= refresh_cnt + 1'b1;
         if (ref_ev) wd_cnt <= '0;
         else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
         if (!ref_ev && wd_cnt == WD_MAX - 1'b1) refresh_late <= 1'b1;
      end
   end
endmodule

// File: tb/tb_freddie_dram_responder.sv
// Directed bench for freddie_dram_responder: table of single accesses plus hand-written sequences.
module tb_freddie_dram_responder;
   import freddie_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b0;
   logic [15:0] access_addr;
   logic        rd_strobe, wr_strobe, refresh_late, prot_err;
   logic [15:0] refresh_cnt;

   int checks   = 0;
   int failures = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   int err_cnt  = 0;
   int exp_ref  = 0;

   freddie_dram_responder_if #(.ADDR_W(8)) bus ();

   freddie_dram_responder #(.REFRESH_WINDOW(16), .ADDR_W(8)) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .bus          (bus),
      .access_addr  (access_addr),
      .rd_strobe    (rd_strobe),
      .wr_strobe    (wr_strobe),
      .refresh_cnt  (refresh_cnt),
      .refresh_late (refresh_late),
      .prot_err     (prot_err)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (rd_strobe) rd_cnt++;
      if (wr_strobe) wr_cnt++;
      if (prot_err)  err_cnt++;
   end

   typedef struct {
      bit         wr;
      logic [7:0] row;
      logic [7:0] col;
      logic [7:0] data;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_pins();
      bus.ras = 1'b1; bus.cas = 1'b1; bus.w = 1'b1;
   endtask

   // One full RAS cycle with a single CAS; checks strobe, address and data timing.
   task automatic access(input bit wr, input logic [7:0] row, input logic [7:0] col,
                         input logic [7:0] data);
      int r0, w0;
      r0 = rd_cnt; w0 = wr_cnt;
      bus.ras = 1'b0; bus.ba = row; tick();
      bus.ba = col; bus.w = ~wr; bus.din = data;
      check("dout_en_before_cas", int'(bus.dout_en), 0);
      bus.cas = 1'b0; tick();
      check("access_addr", int'(access_addr), int'({row, col}));
      if (wr) begin
         check("wr_strobe", int'(wr_strobe), 1);
      end else begin
         check("rd_strobe", int'(rd_strobe), 1);
         check("dout_en", int'(bus.dout_en), 1);
         check("dout", int'(bus.dout), int'(data));
      end
      bus.cas = 1'b1; bus.w = 1'b1; tick();
      check("dout_en_after_cas", int'(bus.dout_en), 0);
      bus.ras = 1'b1; tick();
      check("rd_pulses", rd_cnt - r0, wr ? 0 : 1);
      check("wr_pulses", wr_cnt - w0, wr ? 1 : 0);
      check("refresh_cnt_access", int'(refresh_cnt), exp_ref);
   endtask

   initial begin
      logic [7:0] pcol [3];
      logic [7:0] pdat [3];
      int r0, e0;
      pcol[0] = 8'h01; pcol[1] = 8'h02; pcol[2] = 8'h03;
      pdat[0] = 8'h11; pdat[1] = 8'h22; pdat[2] = 8'h33;
      vecs[0] = '{1'b1, 8'h34, 8'h56, 8'h5A};
      vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'hC3};
      vecs[2] = '{1'b0, 8'h34, 8'h56, 8'h5A};
      vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hC3};
      vecs[4] = '{1'b1, 8'h34, 8'h56, 8'h01};
      vecs[5] = '{1'b0, 8'h34, 8'h56, 8'h01};

      idle_pins(); bus.ba = 8'h00; bus.din = 8'h00;
      tick(); tick();
      check("rst_dout", int'(bus.dout), 0);
      check("rst_dout_en", int'(bus.dout_en), 0);
      check("rst_access_addr", int'(access_addr), 0);
      check("rst_strobes", int'({rd_strobe, wr_strobe, prot_err}), 0);
      check("rst_refresh_cnt", int'(refresh_cnt), 0);
      check("rst_refresh_late", int'(refresh_late), 0);
      check("rst_state", int'(dut.state), int'(IDLE));

      // watchdog: window of 16 cycles from reset release
      rst = 1'b1;
      repeat (15) tick();
      check("late_at_15", int'(refresh_late), 0);
      tick();
      check("late_at_16", int'(refresh_late), 1);
      repeat (4) tick();
      bus.ras = 1'b0; tick();
      bus.ras = 1'b1; tick();
      exp_ref++;
      check("wd_refresh_cnt", int'(refresh_cnt), exp_ref);
      check("late_sticky", int'(refresh_late), 1);

      // write then read at {0x00,0xFF}
      access(1'b1, 8'h00, 8'hFF, 8'hA5);
      access(1'b0, 8'h00, 8'hFF, 8'hA5);

      // page mode writes then reads on row 0x12
      bus.ras = 1'b0; bus.ba = 8'h12; tick();
      for (int i = 0; i < 3; i++) begin
         bus.ba = pcol[i]; bus.din = pdat[i]; bus.w = 1'b0; bus.cas = 1'b0; tick();
         check("page_wr_strobe", int'(wr_strobe), 1);
         bus.cas = 1'b1; bus.w = 1'b1; tick();
      end
      r0 = rd_cnt;
      for (int i = 0; i < 3; i++) begin
         bus.ba = pcol[i]; bus.cas = 1'b0; tick();
         check("page_dout", int'(bus.dout), int'(pdat[i]));
         check("page_addr", int'(access_addr), int'({8'h12, pcol[i]}));
         bus.cas = 1'b1; tick();
      end
      bus.ras = 1'b1; tick();
      check("page_rd_pulses", rd_cnt - r0, 3);
      check("page_refresh_cnt", int'(refresh_cnt), exp_ref);

      // RAS-only then CBR refresh
      e0 = err_cnt;
      bus.ras = 1'b0; bus.ba = 8'h40; tick();
      bus.ras = 1'b1; tick();
      exp_ref++;
      check("ras_only_refresh", int'(refresh_cnt), exp_ref);
      bus.cas = 1'b0; tick();
      check("cbr_arm_no_count", int'(refresh_cnt), exp_ref);
      bus.ras = 1'b0; tick();
      exp_ref++;
      check("cbr_refresh", int'(refresh_cnt), exp_ref);
      idle_pins(); tick();
      check("refresh_no_err", err_cnt - e0, 0);
      check("refresh_state_idle", int'(dut.state), int'(IDLE));

      // simultaneous RAS and CAS fall
      bus.ras = 1'b0; bus.cas = 1'b0; tick();
      exp_ref++;
      check("sim_fall_prot_err", int'(prot_err), 1);
      check("sim_fall_refresh", int'(refresh_cnt), exp_ref);
      tick();
      check("sim_fall_err_pulse_end", int'(prot_err), 0);
      idle_pins(); tick();
      check("sim_fall_err_count", err_cnt - e0, 1);

      // read-modify-write at 0x00FF; CBR above must not have disturbed 0xA5
      bus.ras = 1'b0; bus.ba = 8'h00; tick();
      bus.ba = 8'hFF; bus.cas = 1'b0; tick();
      check("rmw_read_dout", int'(bus.dout), 8'hA5);
      check("rmw_dout_en", int'(bus.dout_en), 1);
      bus.w = 1'b0; bus.din = 8'h3C; tick();
      check("rmw_dout_en_drop", int'(bus.dout_en), 0);
      check("rmw_wr_strobe", int'(wr_strobe), 1);
      idle_pins(); bus.ras = 1'b0; tick();
      bus.ras = 1'b1; tick();
      access(1'b0, 8'h00, 8'hFF, 8'h3C);

      for (int i = 0; i < 6; i++) access(vecs[i].wr, vecs[i].row, vecs[i].col, vecs[i].data);

      // reset during a pending write must not commit it
      bus.ras = 1'b0; bus.ba = 8'h12; tick();
      bus.ba = 8'h01; bus.w = 1'b0; bus.din = 8'h99; bus.cas = 1'b0; rst = 1'b0;
      tick();
      check("rst_mid_wr_strobe", int'(wr_strobe), 0);
      check("rst_mid_state", int'(dut.state), int'(IDLE));
      idle_pins(); tick();
      rst = 1'b1; exp_ref = 0;
      check("rst_mid_refresh_cnt", int'(refresh_cnt), 0);
      access(1'b0, 8'h12, 8'h01, 8'h11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/freddie_dram_responder.md
# freddie_dram_responder

Behavioural DRAM-side responder for the Freddie memory controller: it consumes the multiplexed `ras`/`cas`/`w`/`ba` bus that Freddie drives and behaves as a 64K×8 DRAM bank. It latches the row and column, performs reads and early or read-modify-write cycles, and recognises RAS-only and CAS-before-RAS refresh. It also flags protocol violations and refresh starvation. It closes the loop in Freddie simulations, so benches check data integrity instead of waveforms alone.

## Interface
- `REFRESH_WINDOW`, 4096: max `clk_in` cycles allowed between refresh events before `refresh_late` sets.
- `ADDR_W`, 8: width of `ba`. Row and column are each `ADDR_W` bits; the array holds 2^(2·ADDR_W) bytes.

Ports:
- `clk_in`  in  1  system clock, same clock that drives Freddie.
- `rst`  in  1  asynchronous, active-low reset.
- `ras`  in  1  row strobe, active low.
- `cas`  in  1  column strobe, active low.
- `w`  in  1  write enable, active low.
- `ba`  in  ADDR_W  multiplexed row/column address.
- `din`  in  8  write data.
- `dout`  out  8  read data.
- `dout_en`  out  1  read data driven (tristate enable for the bench).
- `access_addr`  out  2·ADDR_W  {row,col} of the last access.
- `rd_strobe`  out  1  one-cycle pulse when a read completes.
- `wr_strobe`  out  1  one-cycle pulse when a write commits.
- `refresh_cnt`  out  16  refresh events counted, wraps 0xFFFF→0.
- `refresh_late`  out  1  sticky; set when `REFRESH_WINDOW` is exceeded.
- `prot_err`  out  1  one-cycle pulse on an illegal strobe sequence.

## Operation
- `ras`, `cas` and `w` are registered once per `clk_in`. An edge is a difference between the current sample and the registered one. `ba` is taken from the current sample.
- FSM states: IDLE, ROW_OPEN, COL_RD, COL_WR, CBR_ARM, REFRESH.
- IDLE:
  - `ras`↓ with `cas` high → latch row, go to ROW_OPEN.
  - `cas`↓ with `ras` high → CBR_ARM.
  - `ras`↓ and `cas`↓ in the same cycle → pulse `prot_err`, count one refresh, go to REFRESH.
- ROW_OPEN:
  - `cas`↓ latches col and `access_addr`.
  - If `w`=0 at that edge: write `din` to mem, go to COL_WR.
  - Otherwise read, go to COL_RD.
  - `ras`↑ without any CAS during the row → RAS-only refresh: increment `refresh_cnt`, go to IDLE.
  - A row that has performed at least one CAS does not count as a refresh.
- COL_RD:
  - `dout_en`=1.
  - `w`↓ → read-modify-write: write `din` to `access_addr`, go to COL_WR.
  - `cas`↑ → ROW_OPEN (page mode; another `cas`↓ uses the same row).
  - `ras`↑ → pulse `prot_err`, go to IDLE.
- COL_WR:
  - `cas`↑ → ROW_OPEN.
  - `ras`↑ → pulse `prot_err`, go to IDLE.
- CBR_ARM:
  - `ras`↓ → increment `refresh_cnt`, go to REFRESH.
  - `cas`↑ → IDLE; no error, no refresh.
- REFRESH: wait until both `ras` and `cas` are high, then go to IDLE. No mem access occurs.
- Watchdog:
  - The counter clears on each refresh event.
  - When it reaches `REFRESH_WINDOW`, `refresh_late` sets and stays set until reset.
  - The counter saturates at that value.
- Reset mid-access drops the cycle immediately: no write commits and mem is not cleared.

## Timing
- Reset values:
  - `dout`=0, `dout_en`=0, `access_addr`=0, all strobes 0.
  - `refresh_cnt`=0, `refresh_late`=0, state IDLE.
- Edge detection is one cycle after the strobe pin changes, which is the registered sample.
- Write: mem updates at the detecting edge. `wr_strobe` is high for the following cycle.
- Read:
  - `dout` and `rd_strobe` are valid 1 cycle after `cas`↓ detection.
  - `dout_en` rises in the same cycle as `dout`.
  - `dout_en` falls 1 cycle after `cas`↑ or `w`↓ detection.
- `prot_err` and `refresh_cnt` update 1 cycle after the triggering edge.
- If `w` changes in the same cycle as `cas`↓, the new `w` value decides read or write.

## Structure
- Package `freddie_pkg`:
  - `dram_state_t` enum.
  - `ADDR_W` default.
  - Refresh counter width constant.
- Sub-module `freddie_dram_array`:
  - 2^(2·ADDR_W)×8.
  - Synchronous write, registered read.
  - No reset on contents.

## Test plan
1. Reset is held low, then released → all outputs are 0 and state is IDLE.
2. Write cycle:
   - Stimulus: `ras`↓ with `ba`=0x00, then `cas`↓ with `ba`=0xFF, `w`=0, `din`=0xA5.
   - Then a read cycle to the same address.
   - Response: `access_addr`=0x00FF, one `wr_strobe` pulse; on the read, `dout`=0xA5 with `dout_en` one cycle after `cas`↓.
3. Page mode:
   - Stimulus: one row 0x12, three CAS cycles at cols 0x01/0x02/0x03 writing 0x11/0x22/0x33, then read back in page mode.
   - Response: the same three values are returned in order, `refresh_cnt` is unchanged, and there are 3 `rd_strobe` pulses.
4. Refresh counting:
   - Stimulus: one RAS-only cycle, then one CBR cycle (`cas`↓ then `ras`↓).
   - Response: `refresh_cnt`=2, no mem change, `prot_err`=0.
5. Protocol errors and RMW:
   - Stimulus A: `ras`↓ and `cas`↓ in the same cycle. Response: one `prot_err` pulse and `refresh_cnt`+1.
   - Stimulus B: read cycle at 0x00FF with `w`↓ during CAS and `din`=0x3C. Response: mem[0x00FF]=0x3C and `dout_en` drops.
6. Watchdog:
   - Stimulus: `REFRESH_WINDOW`=16 with 20 idle cycles. Response: `refresh_late` sets at cycle 16.
   - Then a refresh is applied. Response: `refresh_late` stays 1.
